mult_datapath: RTL and testbench

- Add-and-shift datapath for the sequential multiplier; sits directly downstream of the multiplier CONTROL FSM.
- Consumes CONTROL's Load/Sh/Ad strobes.
- Returns M (current multiplier LSB) and K (last-shift flag) to CONTROL.
- Holds multiplicand, accumulator and shift counter; presents the 2N-bit product.

---
 rtl/mult_pkg.sv | 17 +
 rtl/mult_shift_counter.sv | 31 +++
 rtl/mult_datapath.sv | 81 ++++++++
 tb/tb_mult_datapath.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared widths for the add-and-shift multiplier datapath.
// Width helpers let non-default N instances derive the same sizes.
package mult_pkg;

   localparam int unsigned DEFAULT_N = 4;
   localparam int unsigned ACC_W     = 2 * DEFAULT_N + 1;
   localparam int unsigned CNT_W     = $clog2(DEFAULT_N);

   function automatic int unsigned acc_width(input int unsigned n);
      return 2 * n + 1;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/mult_shift_counter.sv
// Shift counter for the multiplier datapath: clear, advance, explicit wrap at N-1.
// last flags that the next shift is the Nth one.
module mult_shift_counter
   import mult_pkg::*;
#(
   parameter int unsigned N  = DEFAULT_N,
   parameter int unsigned CW = cnt_width(N)
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   output logic last
);

   localparam logic [CW-1:0] LAST = CW'(N - 1);

   logic [CW-1:0] count;

   // Explicit wrap keeps non-power-of-2 N counting modulo N.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (en) begin
         count <= (count == LAST) ? '0 : count + 1'b1;
      end
   end

   assign last = (count == LAST);

endmodule

// File: rtl/mult_datapath.sv
// Add-and-shift datapath for the sequential multiplier, driven by CONTROL's Load/Sh/Ad.
// Optional sticky over-shift flag err when MULT_DP_PROTOCOL_CHECK_EN is defined.
module mult_datapath
   import mult_pkg::*;
#(
   parameter int unsigned N = DEFAULT_N
) (
   input  logic           Clk,
   input  logic           reset,
   input  logic           Load,
   input  logic           Sh,
   input  logic           Ad,
   input  logic [N-1:0]   Mplier,
   input  logic [N-1:0]   Mcand,
   output logic           M,
   output logic           K,
   output logic [2*N-1:0] Product
`ifdef MULT_DP_PROTOCOL_CHECK_EN
   ,
   output logic           err
`endif
);

   localparam int unsigned AW = acc_width(N);

   logic [AW-1:0] acc;
   logic [N-1:0]  mc;
   logic [N:0]    sum;
   logic          shift_en;

   assign sum      = {1'b0, acc[2*N-1:N]} + {1'b0, mc};
   assign shift_en = Sh && !Load;

   always_ff @(posedge Clk) begin
      if (reset) begin
         acc <= '0;
         mc  <= '0;
      end else if (Load) begin
         acc <= {{(N + 1){1'b0}}, Mplier};
         mc  <= Mcand;
      end else begin
         // Ad+Sh folds the add into the shift so one cycle does both.
         case ({Ad, Sh})
            2'b10:   acc[2*N:N] <= sum;
            2'b01:   acc <= {1'b0, acc[2*N:1]};
            2'b11:   acc <= {1'b0, sum, acc[N-1:1]};
            default: acc <= acc;
         endcase
      end
   end

   mult_shift_counter #(
      .N  (N),
      .CW (cnt_width(N))
   ) u_counter (
      .clk   (Clk),
      .reset (reset),
      .clear (Load),
      .en    (shift_en),
      .last  (K)
   );

   assign M       = acc[0];
   assign Product = acc[2*N-1:0];

`ifdef MULT_DP_PROTOCOL_CHECK_EN
   logic done;

   // done marks that the Nth shift has happened; any later Sh is a protocol error.
   always_ff @(posedge Clk) begin
      if (reset || Load) begin
         done <= 1'b0;
         err  <= 1'b0;
      end else if (Sh) begin
         if (done) err <= 1'b1;
         if (K) done <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_mult_datapath.sv
// Scoreboard bench for mult_datapath: an arithmetic reference model predicts each cycle,
// a negedge monitor pops and compares.
module tb_mult_datapath;

   localparam int unsigned N = 4;

   logic           Clk = 1'b0;
   logic           reset, Load, Sh, Ad;
   logic [N-1:0]   Mplier, Mcand;
   logic           M, K;
   logic [2*N-1:0] Product;
   logic           err_sig;

   mult_datapath #(.N(N)) dut (
      .Clk     (Clk),
      .reset   (reset),
      .Load    (Load),
      .Sh      (Sh),
      .Ad      (Ad),
      .Mplier  (Mplier),
      .Mcand   (Mcand),
      .M       (M),
      .K       (K),
      .Product (Product)
`ifdef MULT_DP_PROTOCOL_CHECK_EN
      ,
      .err     (err_sig)
`endif
   );

`ifndef MULT_DP_PROTOCOL_CHECK_EN
   assign err_sig = 1'b0;
`endif

   always #5 Clk = ~Clk;

   typedef struct {
      logic [2*N-1:0] product;
      logic           m;
      logic           k;
      logic           err;
      string          name;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   // Reference model: accumulator as a plain number.
   int unsigned r_acc, r_mc, r_cnt;
   bit          r_done, r_err;

   task automatic model_step(input bit rst, ld, ad, sh, input int unsigned mp, mcd);
      int unsigned upper, low;
      if (rst) begin
         r_acc = 0; r_mc = 0; r_cnt = 0; r_done = 0; r_err = 0;
      end else if (ld) begin
         r_acc = mp; r_mc = mcd; r_cnt = 0; r_done = 0; r_err = 0;
      end else begin
         if (sh && r_done) r_err = 1;
         if (ad) begin
            upper = ((r_acc / (2 ** N)) % (2 ** N)) + r_mc;
            low   = r_acc % (2 ** N);
            r_acc = upper * (2 ** N) + low;
         end
         if (sh) begin
            r_acc = r_acc / 2;
            if (r_cnt == N - 1) r_done = 1;
            r_cnt = (r_cnt + 1) % N;
         end
      end
   endtask

   task automatic step(input bit rst, ld, ad, sh, input logic [N-1:0] mp, mcd,
                       input string name, input bit ovr, input int unsigned ovr_prod);
      exp_t e;
      reset = rst; Load = ld; Ad = ad; Sh = sh; Mplier = mp; Mcand = mcd;
      @(posedge Clk);
      model_step(rst, ld, ad, sh, mp, mcd);
      e.product = ovr ? (2*N)'(ovr_prod) : (2*N)'(r_acc % (2 ** (2*N)));
      e.m       = r_acc[0];
      e.k       = (r_cnt == N - 1);
      e.err     = r_err;
      e.name    = name;
      exp_q.push_back(e);
      #1;
   endtask

   task automatic idle(input string name);
      step(0, 0, 0, 0, 4'($urandom), 4'($urandom), name, 0, 0);
   endtask

   // Full CONTROL-style sequence; the cycle after the Nth shift checks a*b directly.
   task automatic mul(input int unsigned a, b, input bit comb, input string name);
      step(0, 1, 0, 0, 4'(a), 4'(b), {name, "_load"}, 0, 0);
      for (int i = 0; i < N; i++) begin
         bit fin;
         fin = (i == N - 1);
         if (r_acc[0]) begin
            if (comb) begin
               step(0, 0, 1, 1, 4'($urandom), 4'($urandom), name, fin, a * b);
            end else begin
               step(0, 0, 1, 0, 4'($urandom), 4'($urandom), name, 0, 0);
               step(0, 0, 0, 1, 4'($urandom), 4'($urandom), name, fin, a * b);
            end
         end else begin
            step(0, 0, 0, 1, 4'($urandom), 4'($urandom), name, fin, a * b);
         end
      end
   endtask

   always @(negedge Clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         bit   bad;
         e = exp_q.pop_front();
         vectors++;
         bad = (Product !== e.product) || (M !== e.m) || (K !== e.k);
`ifdef MULT_DP_PROTOCOL_CHECK_EN
         bad = bad || (err_sig !== e.err);
`endif
         if (bad) begin
            miscompares++;
            $display("FAIL %s: got Product=%h M=%b K=%b err=%b, expected Product=%h M=%b K=%b err=%b",
                     e.name, Product, M, K, err_sig, e.product, e.m, e.k, e.err);
         end
      end
   end

   initial begin
      reset = 1; Load = 0; Sh = 0; Ad = 0; Mplier = '0; Mcand = '0;
      step(1, 0, 0, 0, 0, 0, "reset_init", 0, 0);
      step(1, 0, 0, 0, 0, 0, "reset_hold", 0, 0);

      // Reset after activity, including with strobes asserted.
      step(0, 1, 0, 0, 4'h9, 4'h6, "pre_reset_load", 0, 0);
      step(0, 0, 1, 1, 0, 0, "pre_reset_adsh", 0, 0);
      step(1, 0, 1, 1, 0, 0, "reset_after_sh", 0, 0);

      mul(11, 13, 0, "mul_13x11");
      idle("hold_13x11");
      mul(15, 15, 0, "mul_15x15");
      mul(0, 9, 0, "mul_zero");
      mul(5, 3, 1, "mul_5x3_comb");

      // Load wins over simultaneous Ad/Sh.
      step(0, 1, 1, 1, 4'h7, 4'hA, "load_priority", 0, 0);
      for (int i = 0; i < 3; i++) idle("operand_change_no_load");

      // Abort mid-multiply.
      step(0, 1, 0, 0, 4'hE, 4'hB, "abort_load", 0, 0);
      step(0, 0, 1, 1, 0, 0, "abort_adsh", 0, 0);
      step(1, 1, 1, 1, 4'h5, 4'h5, "abort_reset", 0, 0);
      idle("after_abort");

      // Over-shift: err sets after the 5th Sh and stays until Load.
      mul(6, 7, 0, "overshift_mul");
      step(0, 0, 0, 1, 0, 0, "fifth_sh", 0, 0);
      idle("err_sticky");
      step(0, 0, 0, 1, 0, 0, "sixth_sh", 0, 0);
      step(0, 1, 0, 0, 4'h3, 4'h2, "err_cleared_by_load", 0, 0);

      for (int t = 0; t < 40; t++) begin
         int unsigned a, b;
         a = $urandom_range(0, 2**N - 1);
         b = $urandom_range(0, 2**N - 1);
         mul(a, b, 1'($urandom), "rand_mul");
         if ($urandom_range(0, 3) == 0) idle("rand_idle");
      end

      for (int t = 0; t < 60; t++) begin
         step(($urandom_range(0, 15) == 0), ($urandom_range(0, 5) == 0), 1'($urandom), 1'($urandom),
              4'($urandom), 4'($urandom), "rand_strobes", 0, 0);
      end

      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge Clk);
      #1;
      if (exp_q.size() > 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
